// File: rtl/cla_subtractor_pipe_16bit.sv
// Two-stage pipelined subtractor: outData = A - B - bin, built as A + ~B + ~bin from chained 4-bit lookahead groups.
// Optional signed-overflow output is enabled with the SUB_OVF_EN macro.
module cla_subtractor_pipe_16bit #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH*2-1:0]   inData_A,
    input  logic [DATA_WIDTH*2-1:0]   inData_B,
    input  logic                      bin,
    output logic                      out_valid,
    input  logic                      out_ready,
`ifdef SUB_OVF_EN
    output logic                      ovf,
`endif
    output logic [DATA_WIDTH*2-1:0]   outData,
    output logic                      bout
);

    localparam int H  = DATA_WIDTH;
    localparam int NG = DATA_WIDTH / 4;

    // Returns {carry_out, sum[3:0]} for one 4-bit lookahead group.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    logic         s1_valid_q, s1_valid_d;
    logic [H-1:0] s1_diff_lo_q, s1_diff_lo_d;
    logic         s1_carry_q, s1_carry_d;
    logic [H-1:0] s1_a_hi_q, s1_a_hi_d;
    logic [H-1:0] s1_nb_hi_q, s1_nb_hi_d;

    logic         s2_valid_q, s2_valid_d;
    logic [2*H-1:0] out_data_q, out_data_d;
    logic         bout_q, bout_d;
`ifdef SUB_OVF_EN
    logic         ovf_q, ovf_d;
`endif

    logic         s1_ready, s2_ready, in_fire, s1_adv;
    logic [H-1:0] lo_diff, hi_diff;
    logic         lo_carry, hi_carry;

    // Low half: borrow-in enters as an inverted carry.
    always_comb begin
        lo_carry = ~bin;
        lo_diff  = '0;
        for (int g = 0; g < NG; g++) begin
            {lo_carry, lo_diff[g*4 +: 4]} = cla4(inData_A[g*4 +: 4], ~inData_B[g*4 +: 4], lo_carry);
        end
    end

    always_comb begin
        hi_carry = s1_carry_q;
        hi_diff  = '0;
        for (int g = 0; g < NG; g++) begin
            {hi_carry, hi_diff[g*4 +: 4]} = cla4(s1_a_hi_q[g*4 +: 4], s1_nb_hi_q[g*4 +: 4], hi_carry);
        end
    end

    assign s2_ready = ~s2_valid_q | out_ready;
    assign s1_ready = ~s1_valid_q | s2_ready;
    assign in_ready = ~rst & s1_ready;
    assign in_fire  = in_valid & in_ready;
    assign s1_adv   = s1_valid_q & s2_ready;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_diff_lo_d = s1_diff_lo_q;
        s1_carry_d   = s1_carry_q;
        s1_a_hi_d    = s1_a_hi_q;
        s1_nb_hi_d   = s1_nb_hi_q;
        s2_valid_d   = s2_valid_q;
        out_data_d   = out_data_q;
        bout_d       = bout_q;
`ifdef SUB_OVF_EN
        ovf_d        = ovf_q;
`endif

        if (in_fire) begin
            s1_valid_d   = 1'b1;
            s1_diff_lo_d = lo_diff;
            s1_carry_d   = lo_carry;
            s1_a_hi_d    = inData_A[2*H-1:H];
            s1_nb_hi_d   = ~inData_B[2*H-1:H];
        end else if (s2_ready) begin
            s1_valid_d   = 1'b0;
        end

        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
        end

        // Result registers only change when a new result moves in, so they hold while stalled or empty.
        if (s1_adv) begin
            out_data_d = {hi_diff, s1_diff_lo_q};
            bout_d     = ~hi_carry;
`ifdef SUB_OVF_EN
            ovf_d      = (s1_a_hi_q[H-1] ^ ~s1_nb_hi_q[H-1]) & (s1_a_hi_q[H-1] ^ hi_diff[H-1]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_diff_lo_q <= '0;
            s1_carry_q   <= 1'b0;
            s1_a_hi_q    <= '0;
            s1_nb_hi_q   <= '0;
            s2_valid_q   <= 1'b0;
            out_data_q   <= '0;
            bout_q       <= 1'b0;
`ifdef SUB_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_diff_lo_q <= s1_diff_lo_d;
            s1_carry_q   <= s1_carry_d;
            s1_a_hi_q    <= s1_a_hi_d;
            s1_nb_hi_q   <= s1_nb_hi_d;
            s2_valid_q   <= s2_valid_d;
            out_data_q   <= out_data_d;
            bout_q       <= bout_d;
`ifdef SUB_OVF_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign out_valid = s2_valid_q;
    assign outData   = out_data_q;
    assign bout      = bout_q;
`ifdef SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
